rst_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 5 +
 rtl/sync_ff.sv | 17 +
 rtl/rst_seq.sv | 96 +++++++++
 tb/tb_rst_seq.sv | 96 +++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and constants for the reset sequencer
package rst_seq_pkg;
   typedef enum logic [1:0] {S_RESET, S_WAIT_LOCK, S_HOLD, S_RUN} state_e;
   localparam int LOCK_LOSS_W = 8;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: parameterized-depth single-bit synchronizer, resets to 0
module sync_ff #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [DEPTH-1:0] chain_q;
   // shift the asynchronous input through DEPTH flops
   always_ff @(posedge clk) begin
      if (rst) chain_q <= '0;
      else chain_q <= {chain_q[DEPTH-2:0], d_i};
   end
   assign q_o = chain_q[DEPTH-1];
endmodule

// File: rtl/rst_seq.sv
// rst_seq: lock-qualified reset sequencer; RST_SEQ_LOCK_LOSS_CNT_EN enables the lock-loss counter
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_STABLE = 16,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   locked_i,
   output logic                   rst_o,
   output logic                   ready_o,
   output logic [LOCK_LOSS_W-1:0] lock_loss_o
);
   localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   logic          locked_s;
   logic          lock_lost;
   state_e        state_q, state_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          rst_q, ready_q;
   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (locked_i),
      .q_o (locked_s)
   );
   assign lock_lost = !locked_s && (state_q == S_HOLD || state_q == S_RUN);
   // next state and counter updates; lock loss wins over hold completion
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      hold_d  = hold_q;
      case (state_q)
         S_RESET: begin
            state_d = S_WAIT_LOCK;
            stab_d  = '0;
            hold_d  = '0;
         end
         S_WAIT_LOCK: begin
            if (!locked_s) stab_d = '0;
            else if (stab_q == SW'(LOCK_STABLE - 1)) begin
               state_d = S_HOLD;
               hold_d  = '0;
            end else stab_d = stab_q + 1'b1;
         end
         S_HOLD: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               stab_d  = '0;
            end else if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = S_RUN;
            else hold_d = hold_q + 1'b1;
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               stab_d  = '0;
            end
         end
         default: state_d = S_RESET;
      endcase
   end
   // state, counters and glitch-free outputs registered from next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         stab_q  <= '0;
         hold_q  <= '0;
         rst_q   <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         hold_q  <= hold_d;
         rst_q   <= (state_d != S_RUN);
         ready_q <= (state_d == S_RUN);
      end
   end
   assign rst_o   = rst_q;
   assign ready_o = ready_q;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
   logic [LOCK_LOSS_W-1:0] loss_q;
   // saturating count of lock losses out of hold or run
   always_ff @(posedge clk) begin
      if (rst) loss_q <= '0;
      else if (lock_lost && loss_q != '1) loss_q <= loss_q + 1'b1;
   end
   assign lock_loss_o = loss_q;
`else
   logic unused_lock_lost;
   assign unused_lock_lost = lock_lost;
   assign lock_loss_o = '0;
`endif
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: randomized and directed checks of rst_seq against a run-length reference model
module tb_rst_seq;
   import rst_seq_pkg::*;
   localparam int SS = 2, LS = 4, HC = 8, QUAL = LS + HC;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, locked_i = 1'b0;
   logic rst_o, ready_o;
   logic [LOCK_LOSS_W-1:0] lock_loss_o;
   int ncmp = 0, nerr = 0;
   bit dq[$];
   int run = 0, m_cnt = 0;
   rst_seq #(.SYNC_STAGES(SS), .LOCK_STABLE(LS), .HOLD_CYCLES(HC)) dut (
      .clk         (clk),
      .rst         (rst),
      .locked_i    (locked_i),
      .rst_o       (rst_o),
      .ready_o     (ready_o),
      .lock_loss_o (lock_loss_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // model: fabric is ready once the lock sample seen SS edges late has been 1 for QUAL edges in a row
   task automatic step(input bit r, input bit l);
      bit d;
      rst = r;
      locked_i = l;
      @(posedge clk);
      if (r) begin
         dq.delete();
         run = 0;
         m_cnt = 0;
      end else begin
         dq.push_back(l);
         d = (dq.size() > SS) ? dq.pop_front() : 1'b0;
         if (CNT_EN && !d && run >= LS && m_cnt < 255) m_cnt++;
         run = d ? run + 1 : 0;
      end
      #1;
      chk("rst_o", rst_o, run < QUAL);
      chk("ready_o", ready_o, run >= QUAL);
      chk("lock_loss_o", lock_loss_o, m_cnt);
   endtask
   task automatic latency(input string tag);
      int first;
      first = -1;
      for (int i = 1; i <= QUAL + SS + 6; i++) begin
         step(1'b0, 1'b1);
         if (ready_o === 1'b1 && first < 0) first = i;
      end
      chk(tag, first, SS + QUAL);
   endtask
   initial begin
      bit l;
      bit r;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      latency("powerup_latency");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      latency("glitch_latency");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      for (int i = 0; i < SS + LS + 5; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      latency("hold_loss_latency");
      for (int i = 0; i < SS + LS + 3; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      latency("midreset_latency");
      l = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) l = ~l;
         r = ($urandom_range(0, 199) == 0);
         step(r, l);
      end
      step(1'b1, 1'b0);
      for (int i = 0; i < 260; i++) begin
         for (int j = 0; j < 6; j++) step(1'b0, 1'b1);
         for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
      end
      chk("saturated", lock_loss_o, CNT_EN ? 255 : 0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
